// File: rtl/export_call_pkg.sv
// rtl/export_call_pkg.sv - shared constants, FSM state type and pointer-width helper
package export_call_pkg;

    // Stall LFSR: 16-bit Fibonacci, taps 16,14,13,11 (bits 15,13,12,10)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } body_state_t;

    // Pointer width carries one extra wrap bit beyond the address bits
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/export_call_responder_fifo.sv
// rtl/export_call_responder_fifo.sv - show-ahead synchronous FIFO with wrap-bit pointers
module sync_fifo_showahead
    import export_call_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Head is visible without a read strobe; forced to zero while empty
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer advance on accepted write/read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, no reset needed since empty masks stale data
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/export_call_responder.sv
// rtl/export_call_responder.sv - callee endpoint: call FIFO, body handshake, return FIFO, stall injection
module export_call_responder
    import export_call_pkg::*;
#(
    parameter int ARG_WIDTH      = 32,
    parameter int RESULT_WIDTH   = 32,
    parameter int CALL_DEPTH     = 4,
    parameter int RESULT_DEPTH   = 4,
    parameter int STARTUP_CYCLES = 16,
    parameter int STALL_WIDTH    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    rst_and_startup_done_out,
    input  logic                    call_valid_in,
    output logic                    call_rdy_out,
    input  logic [ARG_WIDTH-1:0]    call_arg_in,
    input  logic                    ret_rden_in,
    output logic                    ret_empty_out,
    output logic [RESULT_WIDTH-1:0] ret_data_out,
    output logic                    body_start_out,
    output logic [ARG_WIDTH-1:0]    body_arg_out,
    input  logic                    body_done_in,
    input  logic [RESULT_WIDTH-1:0] body_result_in,
    output logic                    stall_rate_supported_out,
    input  logic                    stall_rate_valid_in,
    input  logic [STALL_WIDTH-1:0]  stall_rate_in
);

    localparam int CRW = ptr_width(RESULT_DEPTH);
    localparam int SCW = $clog2(STARTUP_CYCLES + 1);

    body_state_t            state;
    logic [CRW-1:0]         credit;
    logic [SCW-1:0]         startup_cnt;
    logic [15:0]            lfsr;
    logic [STALL_WIDTH-1:0] stall_rate;
    logic                   stall_now;
    logic                   accept;
    logic                   pop;
    logic                   bypass;
    logic                   call_wr;
    logic                   call_rd;
    logic                   call_empty;
    logic                   call_full;
    logic [ARG_WIDTH-1:0]   call_head;
    logic                   ret_wr;
    logic                   ret_full;

    assign stall_now    = (lfsr[STALL_WIDTH-1:0] < stall_rate);
    assign call_rdy_out = rst_and_startup_done_out && !call_full
                          && (credit < CRW'(RESULT_DEPTH)) && !stall_now;
    assign accept       = call_valid_in && call_rdy_out;
    assign pop          = ret_rden_in && !ret_empty_out;

    // An accept into an idle body with nothing queued goes straight to the body
    assign bypass  = (state == IDLE) && call_empty && accept;
    assign call_wr = accept && !bypass;
    assign call_rd = (state == IDLE) && !call_empty;
    assign ret_wr  = (state == BUSY) && body_done_in && !ret_full;

    sync_fifo_showahead #(.WIDTH(ARG_WIDTH), .DEPTH(CALL_DEPTH)) u_call_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (call_wr),
        .wr_data (call_arg_in),
        .rd_en   (call_rd),
        .rd_data (call_head),
        .empty   (call_empty),
        .full    (call_full)
    );

    sync_fifo_showahead #(.WIDTH(RESULT_WIDTH), .DEPTH(RESULT_DEPTH)) u_ret_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ret_wr),
        .wr_data (body_result_in),
        .rd_en   (ret_rden_in),
        .rd_data (ret_data_out),
        .empty   (ret_empty_out),
        .full    (ret_full)
    );

    // Startup counter; done latches high until the next reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            startup_cnt              <= '0;
            rst_and_startup_done_out <= 1'b0;
            stall_rate_supported_out <= 1'b0;
        end else begin
            stall_rate_supported_out <= 1'b1;
            if (!rst_and_startup_done_out) begin
                startup_cnt <= startup_cnt + 1'b1;
                if (startup_cnt == SCW'(STARTUP_CYCLES - 1)) rst_and_startup_done_out <= 1'b1;
            end
        end
    end

    // Outstanding-call credits bound the return FIFO occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   credit <= credit + 1'b1;
                2'b01:   credit <= credit - 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    // Free-running stall LFSR and loadable stall rate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr       <= LFSR_SEED;
            stall_rate <= '0;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            if (stall_rate_valid_in) stall_rate <= stall_rate_in;
        end
    end

    // Body handshake: one call in flight, start pulse with registered argument
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            body_start_out <= 1'b0;
            body_arg_out   <= '0;
        end else begin
            body_start_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (!call_empty) begin
                        body_start_out <= 1'b1;
                        body_arg_out   <= call_head;
                        state          <= BUSY;
                    end else if (accept) begin
                        body_start_out <= 1'b1;
                        body_arg_out   <= call_arg_in;
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    if (body_done_in) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_export_call_responder.sv
// tb/tb_export_call_responder.sv - self-checking bench for export_call_responder
module tb_export_call_responder;

    localparam int AW = 32;
    localparam int RW = 32;
    localparam int RD = 4;
    localparam int SC = 16;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          done_o;
    logic          call_valid;
    logic          call_rdy;
    logic [AW-1:0] call_arg;
    logic          ret_rden;
    logic          ret_empty;
    logic [RW-1:0] ret_data;
    logic          body_start;
    logic [AW-1:0] body_arg;
    logic          body_done;
    logic [RW-1:0] body_result;
    logic          stall_supported;
    logic          stall_rate_valid;
    logic [SW-1:0] stall_rate;

    always #5 clk = ~clk;

    export_call_responder dut (
        .clk                      (clk),
        .rst                      (rst),
        .rst_and_startup_done_out (done_o),
        .call_valid_in            (call_valid),
        .call_rdy_out             (call_rdy),
        .call_arg_in              (call_arg),
        .ret_rden_in              (ret_rden),
        .ret_empty_out            (ret_empty),
        .ret_data_out             (ret_data),
        .body_start_out           (body_start),
        .body_arg_out             (body_arg),
        .body_done_in             (body_done),
        .body_result_in           (body_result),
        .stall_rate_supported_out (stall_supported),
        .stall_rate_valid_in      (stall_rate_valid),
        .stall_rate_in            (stall_rate)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: results expected in call order, credit count, startup and LFSR position
    logic [RW-1:0] exp_q[$];
    int            outstanding;
    int            edges;
    logic [15:0]   lfsr_m;
    logic [SW-1:0] stall_rate_m;
    logic          exp_rdy;
    logic          last_acc;
    logic          last_pop;
    int            rdy_seen;
    int            rdy_model;

    // Body emulation knobs
    logic [RW-1:0] key;
    int            dmin = 1;
    int            dmax = 1;
    int            start_count = 0;
    int            pend = 0;
    int            bcnt = 0;
    logic [AW-1:0] parg = '0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic fb;
        fb = x[15] ^ x[13] ^ x[12] ^ x[10];
        return {x[14:0], fb};
    endfunction

    // Body: result = arg ^ key, returned a random number of cycles after start
    initial begin
        body_done = 1'b0;
        body_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pend = 0;
                body_done = 1'b0;
            end else begin
                body_done = 1'b0;
                if (pend != 0) begin
                    bcnt--;
                    if (bcnt <= 0) begin
                        body_done = 1'b1;
                        body_result = parg ^ key;
                        pend = 0;
                    end
                end
                if (body_start) begin
                    pend = 1;
                    parg = body_arg;
                    bcnt = int'($urandom_range(dmax, dmin));
                    start_count++;
                end
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        outstanding = 0;
        edges = 0;
        lfsr_m = 16'hACE1;
        stall_rate_m = '0;
    endtask

    // One clock: predict, check ready and popped data, update model, advance
    task automatic cycle();
        logic acc;
        logic pop;
        acc = call_valid && (call_rdy === 1'b1);
        pop = ret_rden && (ret_empty === 1'b0);
        if (!rst) begin
            exp_rdy = (edges >= SC) && (outstanding < RD) && (lfsr_m[SW-1:0] >= stall_rate_m);
            checks++;
            if (call_rdy !== exp_rdy) begin
                failures++;
                $display("FAIL rdy: got %b want %b out=%0d t=%0t", call_rdy, exp_rdy, outstanding, $time);
            end
            if (call_rdy === 1'b1) rdy_seen++;
            if (exp_rdy) rdy_model++;
        end
        if (pop) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got %h want none t=%0t", ret_data, $time);
            end else begin
                if (ret_data !== exp_q[0]) begin
                    failures++;
                    $display("FAIL pop_data: got %h want %h t=%0t", ret_data, exp_q[0], $time);
                end
                void'(exp_q.pop_front());
            end
            outstanding--;
        end
        if (acc) begin
            exp_q.push_back(call_arg ^ key);
            outstanding++;
        end
        last_acc = acc;
        last_pop = pop;
        if (!rst) begin
            lfsr_m = lfsr_step(lfsr_m);
            if (edges < SC) edges++;
            if (stall_rate_valid) stall_rate_m = stall_rate;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_values(input string name);
        logic [6+AW+RW-1:0] got;
        logic [6+AW+RW-1:0] want;
        got  = {done_o, call_rdy, ret_empty, ret_data, body_start, body_arg, stall_supported};
        want = {1'b0, 1'b0, 1'b1, {RW{1'b0}}, 1'b0, {AW{1'b0}}, 1'b0};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic drain();
        call_valid = 1'b0;
        ret_rden = 1'b1;
        for (int i = 0; i < 300 && outstanding != 0; i++) cycle();
        ret_rden = 1'b0;
        checks++;
        if (outstanding != 0) begin
            failures++;
            $display("FAIL drain: got %0d outstanding want 0", outstanding);
        end
    endtask

    task automatic wait_accept(input string name, input int budget);
        last_acc = 1'b0;
        for (int i = 0; i < budget && !last_acc; i++) cycle();
        checks++;
        if (!last_acc) begin
            failures++;
            $display("FAIL %s: got no accept want accept within %0d", name, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (10) begin
            cycle();
            check_reset_values("reset_hold");
        end
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            checks++;
            if (done_o !== (k >= SC) || stall_supported !== 1'b1 || ret_empty !== 1'b1) begin
                failures++;
                $display("FAIL startup_edge%0d: got done=%b sup=%b empty=%b want done=%b sup=1 empty=1",
                         k, done_o, stall_supported, ret_empty, (k >= SC));
            end
        end
    endtask

    task automatic test_single_call();
        key = 32'h1234 ^ 32'hBEEF;
        dmin = 3;
        dmax = 3;
        start_count = 0;
        call_arg = 32'h1234;
        call_valid = 1'b1;
        wait_accept("single_accept", 50);
        call_valid = 1'b0;
        checks++;
        if (body_start !== 1'b1 || body_arg !== 32'h1234) begin
            failures++;
            $display("FAIL start_latency: got start=%b arg=%h want 1 00001234", body_start, body_arg);
        end
        for (int i = 0; i < 20 && body_done !== 1'b1; i++) cycle();
        checks++;
        if (body_done !== 1'b1 || ret_empty !== 1'b1) begin
            failures++;
            $display("FAIL done_cycle: got done=%b empty=%b want 1 1", body_done, ret_empty);
        end
        cycle();
        checks++;
        if (ret_empty !== 1'b0 || ret_data !== 32'hBEEF) begin
            failures++;
            $display("FAIL ret_show: got empty=%b data=%h want 0 0000beef", ret_empty, ret_data);
        end
        ret_rden = 1'b1;
        cycle();
        ret_rden = 1'b0;
        checks++;
        if (ret_empty !== 1'b1 || start_count != 1) begin
            failures++;
            $display("FAIL single_after_pop: got empty=%b starts=%0d want 1 1", ret_empty, start_count);
        end
    endtask

    task automatic test_back_to_back();
        int late_acc;
        key = '0;
        dmin = 2;
        dmax = 2;
        ret_rden = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            call_arg = AW'(i);
            call_valid = 1'b1;
            wait_accept("b2b_accept", 40);
        end
        call_arg = 32'd5;
        late_acc = 0;
        repeat (12) begin
            cycle();
            if (last_acc) late_acc++;
        end
        checks++;
        if (late_acc != 0) begin
            failures++;
            $display("FAIL credit_block: got %0d accepts want 0", late_acc);
        end
        call_valid = 1'b0;
        ret_rden = 1'b1;
        last_pop = 1'b0;
        for (int i = 0; i < 20 && !last_pop; i++) cycle();
        ret_rden = 1'b0;
        call_valid = 1'b1;
        wait_accept("b2b_fifth", 40);
        drain();
    endtask

    task automatic test_reset_midflight();
        int saw_nonempty;
        key = $urandom;
        dmin = 20;
        dmax = 20;
        for (int i = 0; i < 3; i++) begin
            call_arg = $urandom;
            call_valid = 1'b1;
            wait_accept("mid_accept", 40);
        end
        call_valid = 1'b0;
        repeat (3) cycle();
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        model_reset();
        repeat (3) cycle();
        rst = 1'b0;
        start_count = 0;
        saw_nonempty = 0;
        repeat (40) begin
            cycle();
            if (ret_empty !== 1'b1) saw_nonempty++;
        end
        checks++;
        if (saw_nonempty != 0 || start_count != 0) begin
            failures++;
            $display("FAIL post_reset_quiet: got nonempty=%0d starts=%0d want 0 0", saw_nonempty, start_count);
        end
        dmin = 2;
        dmax = 2;
        call_arg = $urandom;
        call_valid = 1'b1;
        wait_accept("fresh_accept", 40);
        drain();
    endtask

    task automatic test_stall();
        int eligible_low;
        key = $urandom;
        dmin = 1;
        dmax = 1;
        stall_rate = 3'd7;
        stall_rate_valid = 1'b1;
        cycle();
        stall_rate_valid = 1'b0;
        rdy_seen = 0;
        rdy_model = 0;
        call_valid = 1'b1;
        ret_rden = 1'b1;
        repeat (1000) begin
            call_arg = $urandom;
            cycle();
        end
        checks++;
        if (rdy_seen != rdy_model || rdy_model < 60 || rdy_model > 250) begin
            failures++;
            $display("FAIL stall7_count: got %0d want %0d (model, near 125)", rdy_seen, rdy_model);
        end
        stall_rate = 3'd0;
        stall_rate_valid = 1'b1;
        cycle();
        stall_rate_valid = 1'b0;
        eligible_low = 0;
        repeat (200) begin
            call_arg = $urandom;
            if (outstanding < RD && call_rdy !== 1'b1) eligible_low++;
            cycle();
        end
        checks++;
        if (eligible_low != 0) begin
            failures++;
            $display("FAIL stall0: got %0d stalled cycles want 0", eligible_low);
        end
        drain();
    endtask

    task automatic test_credit_limit();
        int bad;
        key = $urandom;
        dmin = 1;
        dmax = 1;
        ret_rden = 1'b0;
        call_valid = 1'b1;
        for (int i = 0; i < 60 && outstanding < RD; i++) begin
            call_arg = $urandom;
            cycle();
        end
        repeat (10) cycle();
        checks++;
        if (outstanding != RD || call_rdy !== 1'b0) begin
            failures++;
            $display("FAIL credit_full: got out=%0d rdy=%b want %0d 0", outstanding, call_rdy, RD);
        end
        ret_rden = 1'b1;
        repeat (16) begin
            call_arg = $urandom;
            cycle();
        end
        drain();
        repeat (4) cycle();
        ret_rden = 1'b1;
        bad = 0;
        repeat (5) begin
            cycle();
            if (ret_empty !== 1'b1 || ret_data !== '0 || call_rdy !== 1'b1) bad++;
        end
        ret_rden = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rden_empty: got %0d disturbed cycles want 0", bad);
        end
    endtask

    task automatic test_random();
        key = $urandom;
        dmin = 1;
        dmax = 4;
        repeat (500) begin
            call_valid = ($urandom_range(3, 0) != 0);
            call_arg = $urandom;
            ret_rden = $urandom_range(1, 0) != 0;
            stall_rate_valid = ($urandom_range(19, 0) == 0);
            stall_rate = SW'($urandom_range(7, 0));
            cycle();
        end
        stall_rate_valid = 1'b0;
        drain();
    endtask

    initial begin
        rst = 1'b1;
        call_valid = 1'b0;
        call_arg = '0;
        ret_rden = 1'b0;
        stall_rate_valid = 1'b0;
        stall_rate = '0;
        key = '0;
        last_acc = 1'b0;
        last_pop = 1'b0;
        rdy_seen = 0;
        rdy_model = 0;
        model_reset();
        test_reset();
        test_single_call();
        test_back_to_back();
        test_reset_midflight();
        test_stall();
        test_credit_limit();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
